// File: rtl/dm_arbiter.sv
// dm_arbiter: shares the single-port data memory between the CPU MEM stage (fixed priority)
// and a DMA/debug burst engine with a starvation guard. `DM_ARB_STATS_EN adds stall/beat counters.
module dm_arbiter #(
   parameter int unsigned MAX_WAIT = 4,
   parameter int unsigned ADDR_W   = 8
) (
   input  logic              clk,
   input  logic              clr,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [31:0]       cpu_wdata,
   output logic              cpu_stall,
   output logic [31:0]       cpu_rdata,
   output logic              cpu_rvalid,
   input  logic              dma_start,
   input  logic              dma_we,
   input  logic [ADDR_W-1:0] dma_base,
   input  logic [4:0]        dma_len,
   input  logic [31:0]       dma_wdata,
   output logic              dma_wready,
   output logic [31:0]       dma_rdata,
   output logic              dma_rvalid,
   output logic              dma_busy,
   output logic              dma_done,
   output logic              mem_cs,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
`ifdef DM_ARB_STATS_EN
   output logic [15:0]       stat_cpu_stall,
   output logic [15:0]       stat_dma_beats,
`endif
   input  logic [31:0]       mem_rdata
);

   localparam int unsigned CNT_W  = 4;
   localparam int unsigned IDX_W  = 4;
   localparam int unsigned LEN_W  = 5;
   localparam int unsigned MAX_LEN = 16;

   typedef enum logic [1:0] {S_IDLE, S_BURST, S_DONE} state_e;

   state_e            state_q, state_d;
   logic [IDX_W-1:0]  beat_idx_q, beat_idx_d;
   logic [LEN_W-1:0]  len_q, len_d;
   logic [ADDR_W-1:0] base_q, base_d;
   logic              we_q, we_d;
   logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
   logic              cpu_rvalid_q, cpu_rvalid_d;
   logic [31:0]       cpu_rdata_q, cpu_rdata_d;
   logic              dma_rvalid_q, dma_rvalid_d;
   logic [31:0]       dma_rdata_q, dma_rdata_d;
   logic              dma_busy_q, dma_busy_d;
   logic              dma_done_q, dma_done_d;

   logic force_c, cpu_gnt_c, dma_gnt_c, len_ok_c, last_beat_c;

   // State and output registers
   always_ff @(posedge clk) begin
      if (clr) begin
         state_q      <= S_IDLE;
         beat_idx_q   <= '0;
         len_q        <= '0;
         base_q       <= '0;
         we_q         <= 1'b0;
         wait_cnt_q   <= '0;
         cpu_rvalid_q <= 1'b0;
         cpu_rdata_q  <= '0;
         dma_rvalid_q <= 1'b0;
         dma_rdata_q  <= '0;
         dma_busy_q   <= 1'b0;
         dma_done_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         beat_idx_q   <= beat_idx_d;
         len_q        <= len_d;
         base_q       <= base_d;
         we_q         <= we_d;
         wait_cnt_q   <= wait_cnt_d;
         cpu_rvalid_q <= cpu_rvalid_d;
         cpu_rdata_q  <= cpu_rdata_d;
         dma_rvalid_q <= dma_rvalid_d;
         dma_rdata_q  <= dma_rdata_d;
         dma_busy_q   <= dma_busy_d;
         dma_done_q   <= dma_done_d;
      end
   end

   // Grant, memory drive and next-state logic
   always_comb begin
      state_d      = state_q;
      beat_idx_d   = beat_idx_q;
      len_d        = len_q;
      base_d       = base_q;
      we_d         = we_q;
      wait_cnt_d   = '0;
      cpu_rvalid_d = 1'b0;
      cpu_rdata_d  = cpu_rdata_q;
      dma_rvalid_d = 1'b0;
      dma_rdata_d  = dma_rdata_q;
      mem_cs       = 1'b0;
      mem_we       = 1'b0;
      mem_addr     = '0;
      mem_wdata    = '0;

      force_c     = (state_q == S_BURST) && (wait_cnt_q == CNT_W'(MAX_WAIT));
      cpu_gnt_c   = cpu_req && !force_c;
      dma_gnt_c   = (state_q == S_BURST) && (force_c || !cpu_req);
      len_ok_c    = (dma_len != '0) && (dma_len <= LEN_W'(MAX_LEN));
      last_beat_c = ({1'b0, beat_idx_q} == (len_q - LEN_W'(1)));
      cpu_stall   = cpu_req && force_c;
      dma_wready  = dma_gnt_c && we_q;

      if (cpu_gnt_c) begin
         mem_cs       = 1'b1;
         mem_we       = cpu_we;
         mem_addr     = cpu_addr;
         mem_wdata    = cpu_wdata;
         cpu_rvalid_d = !cpu_we;
         if (!cpu_we) cpu_rdata_d = mem_rdata;
      end else if (dma_gnt_c) begin
         mem_cs       = 1'b1;
         mem_we       = we_q;
         mem_addr     = base_q + ADDR_W'(beat_idx_q);
         mem_wdata    = dma_wdata;
         dma_rvalid_d = !we_q;
         if (!we_q) dma_rdata_d = mem_rdata;
      end

      case (state_q)
         S_IDLE: begin
            if (dma_start && len_ok_c) begin
               state_d    = S_BURST;
               base_d     = dma_base;
               len_d      = dma_len;
               we_d       = dma_we;
               beat_idx_d = '0;
            end
         end
         S_BURST: begin
            if (dma_gnt_c) begin
               if (last_beat_c) begin
                  state_d    = S_DONE;
                  beat_idx_d = '0;
               end else begin
                  beat_idx_d = beat_idx_q + IDX_W'(1);
               end
            end else begin
               wait_cnt_d = wait_cnt_q + CNT_W'(1);
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      dma_busy_d = (state_d == S_BURST);
      dma_done_d = (state_d == S_DONE);
   end

   assign cpu_rdata  = cpu_rdata_q;
   assign cpu_rvalid = cpu_rvalid_q;
   assign dma_rdata  = dma_rdata_q;
   assign dma_rvalid = dma_rvalid_q;
   assign dma_busy   = dma_busy_q;
   assign dma_done   = dma_done_q;

`ifdef DM_ARB_STATS_EN
   logic [15:0] stat_stall_q, stat_beats_q;

   // Saturating activity counters
   always_ff @(posedge clk) begin
      if (clr) begin
         stat_stall_q <= '0;
         stat_beats_q <= '0;
      end else begin
         if (cpu_stall && (stat_stall_q != 16'hFFFF)) stat_stall_q <= stat_stall_q + 16'd1;
         if (dma_gnt_c && (stat_beats_q != 16'hFFFF)) stat_beats_q <= stat_beats_q + 16'd1;
      end
   end

   assign stat_cpu_stall = stat_stall_q;
   assign stat_dma_beats = stat_beats_q;
`endif

endmodule

// File: tb/tb_dm_arbiter.sv
// tb_dm_arbiter: randomized + directed scoreboard bench for dm_arbiter against a
// transaction-level model of the arbitration rules and a shadow copy of memory.
module tb_dm_arbiter;

   localparam int unsigned MAX_WAIT    = 4;
   localparam int unsigned ADDR_W      = 8;
   localparam int unsigned RAND_CYCLES = 3000;

   typedef struct packed {
      logic        c_req;
      logic        c_we;
      logic [7:0]  c_addr;
      logic [31:0] c_wd;
      logic        d_start;
      logic        d_we;
      logic [7:0]  d_base;
      logic [4:0]  d_len;
      logic [31:0] d_wd;
      logic        rst;
   } stim_t;

   typedef struct packed {
      logic        v;
      logic [31:0] data;
      logic [31:0] cyc;
   } exp_t;

   logic              clk = 1'b0;
   logic              clr;
   logic              cpu_req, cpu_we;
   logic [ADDR_W-1:0] cpu_addr;
   logic [31:0]       cpu_wdata;
   logic              cpu_stall;
   logic [31:0]       cpu_rdata;
   logic              cpu_rvalid;
   logic              dma_start, dma_we;
   logic [ADDR_W-1:0] dma_base;
   logic [4:0]        dma_len;
   logic [31:0]       dma_wdata;
   logic              dma_wready;
   logic [31:0]       dma_rdata;
   logic              dma_rvalid, dma_busy, dma_done;
   logic              mem_cs, mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic [31:0]       mem_rdata;
`ifdef DM_ARB_STATS_EN
   logic [15:0]       stat_cpu_stall, stat_dma_beats;
`endif

   always #5 clk = ~clk;

   dm_arbiter #(.MAX_WAIT(MAX_WAIT), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .clr(clr),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_stall(cpu_stall), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
      .dma_start(dma_start), .dma_we(dma_we), .dma_base(dma_base), .dma_len(dma_len),
      .dma_wdata(dma_wdata), .dma_wready(dma_wready), .dma_rdata(dma_rdata),
      .dma_rvalid(dma_rvalid), .dma_busy(dma_busy), .dma_done(dma_done),
      .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
`ifdef DM_ARB_STATS_EN
      .stat_cpu_stall(stat_cpu_stall), .stat_dma_beats(stat_dma_beats),
`endif
      .mem_rdata(mem_rdata)
   );

   // Data memory instance stand-in with a preload port
   logic [31:0] mem [256];
   logic        init_en;
   logic [7:0]  init_addr;
   logic [31:0] init_data;
   always @(posedge clk) begin
      if (init_en) mem[init_addr] <= init_data;
      else if (mem_cs && mem_we) mem[mem_addr] <= mem_wdata;
   end
   assign mem_rdata = mem[mem_addr];

   logic [31:0] cyc = '0;
   always @(posedge clk) cyc <= cyc + 32'd1;

   int   n_cmp = 0;
   int   n_err = 0;
   logic mon_en = 1'b0;
   exp_t cpu_q[$];
   exp_t dma_q[$];

   // Reference model state
   logic [31:0] ref_mem [256];
   logic        m_busy, m_in_done, m_we;
   int          m_rem, m_wait;
   logic [7:0]  m_addr;
   int          m_stall_cnt, m_beats;

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endfunction

   task automatic step(input stim_t s);
      logic       force_m, cpu_srv, dma_srv, exp_cs, exp_we, was_idle, fin;
      logic [7:0] exp_addr;
      logic [31:0] exp_wd;
      chk("dma_busy", 32'(dma_busy), 32'(m_busy));
      chk("dma_done", 32'(dma_done), 32'(m_in_done));
`ifdef DM_ARB_STATS_EN
      chk("stat_cpu_stall", 32'(stat_cpu_stall), 32'(m_stall_cnt));
      chk("stat_dma_beats", 32'(stat_dma_beats), 32'(m_beats));
`endif
      cpu_req = s.c_req;   cpu_we = s.c_we;   cpu_addr = s.c_addr; cpu_wdata = s.c_wd;
      dma_start = s.d_start; dma_we = s.d_we; dma_base = s.d_base;
      dma_len = s.d_len;   dma_wdata = s.d_wd; clr = s.rst;
      #1;
      force_m  = m_busy && (m_wait == int'(MAX_WAIT));
      cpu_srv  = s.c_req && !force_m;
      dma_srv  = m_busy && (force_m || !s.c_req);
      exp_cs   = cpu_srv || dma_srv;
      exp_we   = cpu_srv ? s.c_we : (dma_srv && m_we);
      exp_addr = cpu_srv ? s.c_addr : m_addr;
      exp_wd   = cpu_srv ? s.c_wd : s.d_wd;
      chk("cpu_stall", 32'(cpu_stall), 32'(s.c_req && force_m));
      chk("mem_cs", 32'(mem_cs), 32'(exp_cs));
      chk("dma_wready", 32'(dma_wready), 32'(dma_srv && m_we));
      if (exp_cs) begin
         chk("mem_we", 32'(mem_we), 32'(exp_we));
         chk("mem_addr", 32'(mem_addr), 32'(exp_addr));
         if (exp_we) chk("mem_wdata", mem_wdata, exp_wd);
      end
      if (cpu_srv) begin
         if (s.c_we) ref_mem[s.c_addr] = s.c_wd;
         else if (!s.rst) cpu_q.push_back('{v: 1'b1, data: ref_mem[s.c_addr], cyc: cyc + 32'd1});
      end
      if (dma_srv) begin
         if (m_we) ref_mem[m_addr] = s.d_wd;
         else if (!s.rst) dma_q.push_back('{v: 1'b1, data: ref_mem[m_addr], cyc: cyc + 32'd1});
      end
      if (s.c_req && force_m && m_stall_cnt < 65535) m_stall_cnt++;
      if (dma_srv && m_beats < 65535) m_beats++;
      // Burst bookkeeping: beats left, next address, consecutive blocked cycles
      was_idle = !m_busy && !m_in_done;
      fin = 1'b0;
      if (dma_srv) begin
         m_addr = m_addr + 8'd1;
         m_rem--;
         m_wait = 0;
         if (m_rem == 0) begin
            m_busy = 1'b0;
            fin    = 1'b1;
         end
      end else if (m_busy) begin
         m_wait++;
      end
      if (was_idle && s.d_start && s.d_len >= 5'd1 && s.d_len <= 5'd16) begin
         m_busy = 1'b1;
         m_rem  = int'(s.d_len);
         m_addr = s.d_base;
         m_we   = s.d_we;
         m_wait = 0;
      end
      m_in_done = fin;
      if (s.rst) begin
         m_busy = 1'b0; m_in_done = 1'b0; m_rem = 0; m_wait = 0;
         m_stall_cnt = 0; m_beats = 0;
         cpu_q.push_back('{v: 1'b0, data: 32'h0, cyc: cyc + 32'd1});
         dma_q.push_back('{v: 1'b0, data: 32'h0, cyc: cyc + 32'd1});
      end
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      stim_t s;
      s = '0;
      for (int i = 0; i < n; i++) step(s);
   endtask

   task automatic cpu_acc(input logic we, input logic [7:0] addr, input logic [31:0] wd);
      stim_t s;
      s = '0;
      s.c_req = 1'b1; s.c_we = we; s.c_addr = addr; s.c_wd = wd;
      step(s);
   endtask

   task automatic dma_go(input logic we, input logic [7:0] base, input logic [4:0] len);
      stim_t s;
      s = '0;
      s.d_start = 1'b1; s.d_we = we; s.d_base = base; s.d_len = len; s.d_wd = $urandom;
      step(s);
   endtask

   // Monitor: pops the scoreboard whenever a registered response is due
   initial begin : monitor
      exp_t        e;
      logic [31:0] cpu_last, dma_last;
      cpu_last = '0;
      dma_last = '0;
      wait (mon_en);
      forever begin
         @(posedge clk);
         #1;
         if (cpu_q.size() > 0 && cpu_q[0].cyc == cyc) begin
            e = cpu_q.pop_front();
            chk("cpu_rvalid", 32'(cpu_rvalid), 32'(e.v));
            chk("cpu_rdata", cpu_rdata, e.data);
            cpu_last = e.data;
         end else begin
            chk("cpu_rvalid_idle", 32'(cpu_rvalid), 32'h0);
            chk("cpu_rdata_hold", cpu_rdata, cpu_last);
         end
         if (dma_q.size() > 0 && dma_q[0].cyc == cyc) begin
            e = dma_q.pop_front();
            chk("dma_rvalid", 32'(dma_rvalid), 32'(e.v));
            chk("dma_rdata", dma_rdata, e.data);
            dma_last = e.data;
         end else begin
            chk("dma_rvalid_idle", 32'(dma_rvalid), 32'h0);
            chk("dma_rdata_hold", dma_rdata, dma_last);
         end
      end
   end

   initial begin : driver
      stim_t s;
      clr = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
      dma_start = 1'b0; dma_we = 1'b0; dma_base = '0; dma_len = '0; dma_wdata = '0;
      m_busy = 1'b0; m_in_done = 1'b0; m_we = 1'b0; m_rem = 0; m_wait = 0; m_addr = '0;
      m_stall_cnt = 0; m_beats = 0;
      init_en = 1'b1; init_addr = '0; init_data = '0;
      for (int i = 0; i < 256; i++) begin
         init_addr    = 8'(i);
         init_data    = $urandom;
         ref_mem[i]   = init_data;
         @(negedge clk);
      end
      init_en = 1'b0;

      chk("reset_cpu_rvalid", 32'(cpu_rvalid), 32'h0);
      chk("reset_cpu_rdata", cpu_rdata, 32'h0);
      chk("reset_dma_rvalid", 32'(dma_rvalid), 32'h0);
      chk("reset_dma_rdata", dma_rdata, 32'h0);
      mon_en = 1'b1;

      // CPU single-word write then read-back
      cpu_acc(1'b1, 8'h10, 32'hDEADBEEF);
      cpu_acc(1'b0, 8'h10, 32'h0);
      idle(2);

      // DMA read burst with the CPU idle
      for (int i = 0; i < 4; i++) cpu_acc(1'b1, 8'(32'h20 + i), 32'(i + 1));
      dma_go(1'b0, 8'h20, 5'd4);
      idle(7);

      // Starvation: write burst while the CPU requests every cycle
      s = '0;
      s.c_req = 1'b1; s.c_addr = 8'h05;
      s.d_start = 1'b1; s.d_we = 1'b1; s.d_base = 8'h40; s.d_len = 5'd2; s.d_wd = $urandom;
      step(s);
      s.d_start = 1'b0;
      for (int i = 0; i < 13; i++) begin
         s.d_wd = $urandom;
         step(s);
      end
      idle(2);
      cpu_acc(1'b0, 8'h40, 32'h0);
      cpu_acc(1'b0, 8'h41, 32'h0);
      idle(2);

      // Address wrap-around at the top of memory
      dma_go(1'b1, 8'hFE, 5'd4);
      for (int i = 0; i < 5; i++) begin
         s = '0; s.d_wd = $urandom; step(s);
      end
      dma_go(1'b0, 8'hFE, 5'd4);
      idle(7);

      // Ignored starts: illegal lengths, and starts while busy
      dma_go(1'b0, 8'h60, 5'd0);
      idle(2);
      dma_go(1'b0, 8'h60, 5'd17);
      idle(2);
      dma_go(1'b0, 8'h80, 5'd3);
      for (int i = 0; i < 4; i++) dma_go(1'b1, 8'h90, 5'd16);
      idle(3);

      // Reset in the middle of a read burst
      dma_go(1'b0, 8'h30, 5'd8);
      idle(2);
      s = '0; s.rst = 1'b1; step(s);
      idle(6);

      // Randomized traffic
      for (int i = 0; i < int'(RAND_CYCLES); i++) begin
         s.c_req   = ($urandom_range(0, 9) < 6);
         s.c_we    = $urandom_range(0, 1) == 1;
         s.c_addr  = 8'($urandom_range(0, 255));
         s.c_wd    = $urandom;
         s.d_start = ($urandom_range(0, 11) == 0);
         s.d_we    = $urandom_range(0, 1) == 1;
         s.d_base  = 8'($urandom_range(0, 255));
         s.d_len   = 5'($urandom_range(0, 20));
         s.d_wd    = $urandom;
         s.rst     = ($urandom_range(0, 599) == 0);
         step(s);
      end
      idle(25);

      chk("cpu_q_drained", 32'(cpu_q.size()), 32'h0);
      chk("dma_q_drained", 32'(dma_q.size()), 32'h0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/dm_arbiter.md
Name: dm_arbiter

Overview:
- Shares the single-port 256x32 data memory between two requesters: the CPU MEM stage (single-word accesses) and a DMA/debug engine (bursts).
- CPU has fixed priority.
- A starvation counter forces a DMA beat after MAX_WAIT blocked cycles; the CPU is stalled for that one cycle.
- Sits between the MEM stage and the data memory instance; one access per clock.

Parameters:
- MAX_WAIT, 4, consecutive DMA-blocked cycles before a DMA beat is forced (1..15).
- ADDR_W, 8, word address width into data memory.

Ports:
- clk  in  1  global clock
- clr  in  1  synchronous active-high reset
- cpu_req  in  1  CPU access request this cycle
- cpu_we  in  1  1=write, 0=read
- cpu_addr  in  ADDR_W  word address
- cpu_wdata  in  32  write data
- cpu_stall  out  1  combinational; CPU access not served this cycle, hold request
- cpu_rdata  out  32  registered read data
- cpu_rvalid  out  1  registered; cpu_rdata valid
- dma_start  in  1  start-burst pulse; sampled in IDLE only
- dma_we  in  1  burst direction, 1=write
- dma_base  in  ADDR_W  burst start address
- dma_len  in  5  beats, 1..16; 0 and 17..31 ignored
- dma_wdata  in  32  current write beat data
- dma_wready  out  1  combinational; write beat consumed this cycle, source advances
- dma_rdata  out  32  registered read beat
- dma_rvalid  out  1  registered
- dma_busy  out  1  registered; burst in progress
- dma_done  out  1  registered one-cycle pulse
- mem_cs, mem_we  out  1 each  memory select / write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  32  memory write data
- mem_rdata  in  32  combinational read data from memory

Behaviour:
- Reset (clr=1 at posedge): state=IDLE; beat_idx=0; wait_cnt=0; all registered outputs=0. Combinational outputs become 0/idle from that cycle. Reset mid-burst aborts the burst: no dma_done, and no further mem access.
- States:
  - IDLE: dma_start=1 with legal dma_len latches base/len/we, goes to BURST; dma_busy=1 next cycle. Start with an illegal length is ignored. Start outside IDLE is ignored.
  - BURST: issues beats.
  - DONE: lasts one cycle with dma_done=1, dma_busy=0, then returns to IDLE.
- Grant each cycle:
  - force = (state==BURST && wait_cnt==MAX_WAIT).
  - If force: DMA wins and cpu_stall=cpu_req.
  - Else if cpu_req: CPU wins and cpu_stall=0.
  - Else if BURST: DMA wins.
  - Else no access (mem_cs=0).
- Memory drive:
  - CPU grant: mem_cs=1, mem_we=cpu_we, mem_addr=cpu_addr, mem_wdata=cpu_wdata.
  - DMA grant: mem_addr=(base+beat_idx) mod 2^ADDR_W (wraps 255->0), mem_we=latched we, mem_wdata=dma_wdata.
  - dma_wready=1 only on a granted DMA write beat.
- wait_cnt:
  - Increments when BURST and the DMA is not granted.
  - Clears on any DMA grant, and in IDLE/DONE.
  - Never exceeds MAX_WAIT.
- Read latency 1:
  - A granted read returns mem_rdata on cpu_rdata/dma_rdata with rvalid=1 the following cycle.
  - Writes produce no rvalid.
  - rdata holds its last value when rvalid=0.
- beat_idx increments per DMA grant. On the grant where beat_idx==len-1, the next state is DONE, so dma_done coincides with the last dma_rvalid for reads.
- CPU access during the DONE cycle is served normally.

Optional Feature:
- Macro: DM_ARB_STATS_EN.
- Enabled: adds ports stat_cpu_stall (out 16) and stat_dma_beats (out 16).
  - stat_cpu_stall counts cycles with cpu_stall=1.
  - stat_dma_beats counts granted DMA beats.
  - Both saturate at 16'hFFFF and clear on clr.
- Disabled: those ports and counters do not exist; all other behaviour is identical.

Test Plan:
- CPU read only: preload mem[0x10]=0xDEADBEEF, cpu_req=1 read addr 0x10 -> cpu_stall=0; next cycle cpu_rvalid=1, cpu_rdata=0xDEADBEEF.
- DMA read burst, CPU idle: base=0x20, len=4, mem[0x20..0x23]=1..4 -> dma_rvalid on 4 consecutive cycles with data 1,2,3,4; dma_done pulses with the 4th; dma_busy drops the same cycle.
- Starvation, MAX_WAIT=4: DMA write burst len=2, cpu_req held high continuously -> cpu_stall=1 exactly on the 5th BURST cycle and again 5 cycles later; 2 dma_wready pulses; memory holds both words.
- Wrap-around: base=0xFE, len=4 write -> beats hit addresses 0xFE, 0xFF, 0x00, 0x01.
- Illegal/ignored starts: dma_len=0 -> no busy. dma_start during BURST -> original burst length and base unchanged.
- Reset mid-burst: clr at beat 2 of len=8 -> next cycle dma_busy=0, dma_done never asserted, mem_cs=0 with no CPU request; with DM_ARB_STATS_EN, counters read 0.
